// File: rtl/count_up_timer.sv
// -----------------------------------------------------------------------------
// count_up_timer
//   Two-digit BCD stopwatch. A start/stop push-button starts, pauses and
//   resumes counting. Counting stops at a switch-selected target, and the
//   count is shown on two active-low 7-segment digits.
//
// Optional build macro:
//   LAP_HOLD_EN - when defined, the lap button freezes the display on the count
//                 captured at the press. Counting continues underneath.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   start_stop  in   start/stop push-button, active-low, asynchronous
//   clear       in   synchronous active-high clear to IDLE / 00
//   lap         in   lap push-button, active-low (LAP_HOLD_EN builds only)
//   blank       in   1 = both digits dark, counting unaffected
//   target1/2   in   target ones/tens digit, BCD
//   bcd1/2      out  live ones/tens digit
//   running     out  1 while in RUN
//   done        out  1 while in DONE
//   l1/l2       out  ones/tens segments, active-low, bit6=a .. bit0=g
// -----------------------------------------------------------------------------

// Button conditioner: synchronizer chain followed by a falling-edge detector.
// press_o is a single-cycle pulse per press. Holding the button produces nothing more.
module count_up_timer_btn #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n_i,
    output logic press_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign press_o = prev_q & ~sync_q[SYNC_STAGES-1];
endmodule

// State | meaning
// IDLE  | count 00, waiting for a start press
// RUN   | prescaler running, count increments on each tick
// PAUSED| count and prescaler frozen, waiting for a resume press
// DONE  | count held at target (or 99), waiting for a press to return to IDLE
module count_up_timer #(
    parameter int TICK_CYCLES = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    input  logic       blank,
    input  logic [3:0] target1,
    input  logic [3:0] target2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic       running,
    output logic       done,
    output logic [6:0] l1,
    output logic [6:0] l2
);
    localparam int            PW        = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    state_t        state_q;
    logic [3:0]    bcd1_q, bcd2_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, done_q;
    logic          ss_press;
    logic          tick;
    logic          at_99;
    logic          hit_target;
    logic [3:0]    inc1_d, inc2_d;
    logic [3:0]    eff1, eff2;
    logic [3:0]    disp1, disp2;

    count_up_timer_btn #(.SYNC_STAGES(SYNC_STAGES)) u_ss_btn (
        .clock   (clock),
        .reset   (reset),
        .btn_n_i (start_stop),
        .press_o (ss_press)
    );

`ifdef LAP_HOLD_EN
    logic       lap_press;
    logic       hold_q;
    logic [3:0] hold1_q, hold2_q;

    count_up_timer_btn #(.SYNC_STAGES(SYNC_STAGES)) u_lap_btn (
        .clock   (clock),
        .reset   (reset),
        .btn_n_i (lap),
        .press_o (lap_press)
    );
`else
    logic unused_lap;
    assign unused_lap = lap;
`endif

    // An out-of-range or 00 target means "run to the top".
    always_comb begin
        eff1 = target1;
        eff2 = target2;
        if (target1 > 4'd9 || target2 > 4'd9 || {target2, target1} == 8'h00) begin
            eff1 = 4'd9;
            eff2 = 4'd9;
        end
    end

    always_comb begin
        inc1_d = bcd1_q + 4'd1;
        inc2_d = bcd2_q;
        if (bcd1_q == 4'd9) begin
            inc1_d = 4'd0;
            inc2_d = bcd2_q + 4'd1;
        end
    end

    assign tick       = (state_q == S_RUN) && (presc_q == TICK_LAST);
    assign presc_d    = tick ? '0 : presc_q + 1'b1;
    assign at_99      = (bcd1_q == 4'd9) && (bcd2_q == 4'd9);
    assign hit_target = (inc1_d == eff1) && (inc2_d == eff2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bcd1_q    <= 4'd0;
            bcd2_q    <= 4'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef LAP_HOLD_EN
            hold_q    <= 1'b0;
            hold1_q   <= 4'd0;
            hold2_q   <= 4'd0;
`endif
        end else if (clear) begin
            state_q   <= S_IDLE;
            bcd1_q    <= 4'd0;
            bcd2_q    <= 4'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef LAP_HOLD_EN
            hold_q    <= 1'b0;
`endif
        end else begin
`ifdef LAP_HOLD_EN
            // Toggle the hold. Transitions into DONE below override this.
            if (lap_press && (state_q == S_RUN || state_q == S_PAUSED)) begin
                hold_q  <= ~hold_q;
                hold1_q <= bcd1_q;
                hold2_q <= bcd2_q;
            end
`endif
            case (state_q)
                S_IDLE: begin
                    if (ss_press) begin
                        state_q   <= S_RUN;
                        presc_q   <= '0;
                        running_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    presc_q <= presc_d;
                    if (tick) begin
                        // At 99 the count never wraps, even if the target was
                        // moved below the count while running.
                        if (at_99 || hit_target) begin
                            state_q   <= S_DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
`ifdef LAP_HOLD_EN
                            hold_q    <= 1'b0;
`endif
                        end else if (ss_press) begin
                            state_q   <= S_PAUSED;
                            running_q <= 1'b0;
                        end
                        if (!at_99) begin
                            bcd1_q <= inc1_d;
                            bcd2_q <= inc2_d;
                        end
                    end else if (ss_press) begin
                        state_q   <= S_PAUSED;
                        running_q <= 1'b0;
                    end
                end
                S_PAUSED: begin
                    if (ss_press) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (ss_press) begin
                        state_q <= S_IDLE;
                        bcd1_q  <= 4'd0;
                        bcd2_q  <= 4'd0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef LAP_HOLD_EN
    assign disp1 = hold_q ? hold1_q : bcd1_q;
    assign disp2 = hold_q ? hold2_q : bcd2_q;
`else
    assign disp1 = bcd1_q;
    assign disp2 = bcd2_q;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign l1      = blank ? 7'b1111111 : seg7(disp1);
    assign l2      = blank ? 7'b1111111 : seg7(disp2);
    assign bcd1    = bcd1_q;
    assign bcd2    = bcd2_q;
    assign running = running_q;
    assign done    = done_q;
endmodule

// File: tb/tb_count_up_timer.sv
module tb_count_up_timer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_stop = 1'b1;
    logic       clear = 1'b0;
    logic       lap = 1'b1;
    logic       blank = 1'b0;
    logic [3:0] target1 = 4'd0;
    logic [3:0] target2 = 4'd0;
    logic [3:0] bcd1, bcd2;
    logic       running, done;
    logic [6:0] l1, l2;

    count_up_timer #(.TICK_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .start_stop(start_stop), .clear(clear),
        .lap(lap), .blank(blank), .target1(target1), .target2(target2),
        .bcd1(bcd1), .bcd2(bcd2), .running(running), .done(done),
        .l1(l1), .l2(l2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] t2;
        logic [3:0] t1;
        logic [7:0] fin;
        logic [6:0] l2;
        logic [6:0] l1;
    } vec_t;

    vec_t       vecs[8];
    logic [6:0] seg_tab[10];
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] exp_q[$];
    logic       mon_en = 1'b0;
    logic [7:0] last_cnt = 8'h00;
    logic [7:0] mon_cur, mon_exp;

    // Scoreboard: every change of the live count is popped and compared.
    always @(negedge clock) begin
        mon_cur = {bcd2, bcd1};
        if (mon_en && mon_cur !== last_cnt) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: count %0h, required no change from %0h", mon_cur, last_cnt);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_exp !== mon_cur) begin
                    n_fail++;
                    $display("FAIL sb_count: got %0h, required %0h", mon_cur, mon_exp);
                end
            end
        end
        last_cnt = mon_cur;
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    task automatic push_seq(input logic [7:0] from, input logic [7:0] upto);
        logic [7:0] c;
        c = from;
        while (c != upto) begin
            c = bcd_inc(c);
            exp_q.push_back(c);
        end
    endtask

    task automatic press_ss();
        start_stop = 1'b0;
        repeat (4) step();
        start_stop = 1'b1;
        repeat (4) step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
    endtask

    task automatic wait_cnt(input logic [7:0] v, input int budget, input string nm);
        int i;
        i = 0;
        while ({bcd2, bcd1} !== v && i < budget) begin
            step();
            i++;
        end
        chk(nm, {bcd2, bcd1}, v);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int i;
        i = 0;
        while (done !== 1'b1 && i < budget) begin
            step();
            i++;
        end
        chk(nm, done, 1);
    endtask

    initial begin
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
        seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
        seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;

        vecs[0] = '{4'h0, 4'h5, 8'h05, 7'b0000001, 7'b0100100};
        vecs[1] = '{4'h1, 4'h2, 8'h12, 7'b1001111, 7'b0010010};
        vecs[2] = '{4'h0, 4'h8, 8'h08, 7'b0000001, 7'b0000000};
        vecs[3] = '{4'h0, 4'h1, 8'h01, 7'b0000001, 7'b1001111};
        vecs[4] = '{4'h2, 4'h6, 8'h26, 7'b0010010, 7'b0100000};
        vecs[5] = '{4'h1, 4'hF, 8'h99, 7'b0000100, 7'b0000100};
        vecs[6] = '{4'h0, 4'h0, 8'h99, 7'b0000100, 7'b0000100};
        vecs[7] = '{4'hA, 4'h3, 8'h99, 7'b0000100, 7'b0000100};

        // Reset state
        #23 reset = 1'b1;
        step();
        chk("rst_l1", l1, 7'b0000001);
        chk("rst_l2", l2, 7'b0000001);
        chk("rst_bcd", {bcd2, bcd1}, 8'h00);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        repeat (10) step();
        chk("idle_stays", {running, done, bcd2, bcd1}, 10'h000);
        blank = 1'b1;
        #1 chk("rst_blank", {l2, l1}, 14'h3FFF);
        blank = 1'b0;

        // Table-driven full runs to target
        for (int i = 0; i < 8; i++) begin
            target2 = vecs[i].t2;
            target1 = vecs[i].t1;
            do_clear();
            mon_en = 1'b1;
            push_seq(8'h00, vecs[i].fin);
            press_ss();
            wait_done(600, "vec_done");
            step();
            chk("vec_sb_drained", exp_q.size(), 0);
            chk("vec_final", {bcd2, bcd1}, vecs[i].fin);
            chk("vec_l2", l2, vecs[i].l2);
            chk("vec_l1", l1, vecs[i].l1);
            chk("vec_running", running, 0);
            blank = 1'b1;
            step();
            chk("vec_blank", {l2, l1}, 14'h3FFF);
            blank = 1'b0;
            repeat (50) step();
            chk("vec_hold", {done, bcd2, bcd1}, {1'b1, vecs[i].fin});
            exp_q.push_back(8'h00);
            press_ss();
            chk("vec_back_idle", {done, running, bcd2, bcd1}, 10'h000);
            mon_en = 1'b0;
            exp_q.delete();
        end

        // Start latency, pause, partial-prescaler resume
        target2 = 4'd0; target1 = 4'd0;
        do_clear();
        mon_en = 1'b1;
        push_seq(8'h00, 8'h04);
        start_stop = 1'b0;
        step(); step();
        chk("start_lat_2", running, 0);
        step();
        chk("start_lat_3", running, 1);
        start_stop = 1'b1;
        wait_cnt(8'h03, 40, "pause_reach_03");
        start_stop = 1'b0;
        repeat (3) step();
        chk("pause_enter", {running, done}, 2'b00);
        start_stop = 1'b1;
        repeat (40) step();
        chk("pause_frozen", {bcd2, bcd1}, 8'h03);
        start_stop = 1'b0;
        repeat (3) step();
        chk("resume_run", {running, bcd2, bcd1}, {1'b1, 8'h03});
        step();
        chk("resume_partial", {bcd2, bcd1}, 8'h04);
        start_stop = 1'b1;
        step();
        chk("pause_sb_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        exp_q.delete();
        do_clear();

        // Clear beats a same-cycle press; a long hold is a single press
        press_ss();
        wait_cnt(8'h02, 40, "clr_reach_02");
        start_stop = 1'b0;
        step(); step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_over_press", {running, done, bcd2, bcd1}, 10'h000);
        repeat (20) step();
        chk("clr_no_repress", running, 0);
        start_stop = 1'b1;
        repeat (4) step();
        start_stop = 1'b0;
        repeat (100) step();
        chk("long_hold_one_press", running, 1);
        start_stop = 1'b1;
        repeat (4) step();
        chk("long_release_no_press", running, 1);
        do_clear();

        // Target lowered below the count while running: run to 99 and stop
        target2 = 4'd2; target1 = 4'd0;
        mon_en = 1'b1;
        push_seq(8'h00, 8'h99);
        press_ss();
        wait_cnt(8'h10, 100, "lower_reach_10");
        target2 = 4'd0; target1 = 4'd5;
        wait_done(600, "lower_done");
        step();
        chk("lower_final_99", {bcd2, bcd1}, 8'h99);
        chk("lower_sb_drained", exp_q.size(), 0);
        repeat (12) step();
        chk("lower_no_wrap", {done, bcd2, bcd1}, {1'b1, 8'h99});
        mon_en = 1'b0;
        exp_q.delete();
        do_clear();

        // Asynchronous reset mid-count
        target2 = 4'h1; target1 = 4'hF;
        press_ss();
        wait_cnt(8'h47, 300, "areset_reach_47");
        #1 reset = 1'b0;
        #1 chk("areset_bcd", {bcd2, bcd1}, 8'h00);
        chk("areset_running", running, 0);
        #3 reset = 1'b1;
        step();
        chk("areset_idle", {running, done, bcd2, bcd1}, 10'h000);

        // Lap button
        target2 = 4'd0; target1 = 4'd0;
        do_clear();
        press_ss();
        wait_cnt(8'h20, 150, "lap_reach_20");
        lap = 1'b0;
        repeat (3) step();
        lap = 1'b1;
        wait_cnt(8'h23, 40, "lap_reach_23");
`ifdef LAP_HOLD_EN
        chk("lap_held_l1", l1, seg_tab[0]);
`else
        chk("lap_ignored_l1", l1, seg_tab[3]);
`endif
        chk("lap_l2", l2, seg_tab[2]);
        lap = 1'b0;
        repeat (3) step();
        lap = 1'b1;
        wait_cnt(8'h25, 40, "lap_reach_25");
        chk("lap_live_l1", l1, seg_tab[5]);
        chk("lap_live_l2", l2, seg_tab[2]);
        do_clear();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
